// File: rtl/strobe_decoder_pkg.sv
// strobe_decoder_pkg
//   Shared definitions for the strobe decoder:
//     state_e     - FSM states (IDLE, PULSE, GAP)
//     CNT_W       - width of the pulse/gap down-counter (holds 1..255)
//     line_level  - maps a logical "line on" bit to its electrical level
package strobe_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int CNT_W = 8;

  // Active-low lines are driven to 0 when on, 1 when off.
  function automatic logic line_level(input logic active_low, input logic on);
    return on ^ active_low;
  endfunction

endpackage

// File: rtl/onehot_decode.sv
// onehot_decode
//   Purely combinational select decoder. sel_i = 0 lights the MSB, so
//   output bit N-1-sel_i is the single bit set.
//   Ports:
//     sel_i     [SEL_W-1:0]  line index
//     onehot_o  [N-1:0]      one-hot decode, MSB-first ordering
module onehot_decode
  import strobe_decoder_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int N     = 2 ** SEL_W
) (
  input  logic [SEL_W-1:0] sel_i,
  output logic [N-1:0]     onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < N; i++) begin
      onehot_o[i] = (sel_i == SEL_W'(N - 1 - i));
    end
  end

endmodule

// File: rtl/strobe_decoder.sv
// strobe_decoder
//   Accepts a strobe request while idle and enabled, drives one of N strobe
//   lines active for PULSE_CYCLES cycles, then holds all lines inactive for
//   DEAD_CYCLES cycles before becoming ready again. Losing enable during the
//   pulse cuts it short and reports aborted instead of done.
//   Ports:
//     clk      system clock, rising edge
//     rst      synchronous active-high reset
//     en_g1    enable, active-high
//     en_g2    [1:0] enables, both active-low
//     req      strobe request, taken only while ready and enabled
//     sel      [SEL_W-1:0] line index, sampled on accept
//     ready    high only in IDLE
//     strobe   [N-1:0] registered strobe lines (one-cold when ACTIVE_LOW=1)
//     done     one-cycle pulse after a full-length pulse
//     aborted  one-cycle pulse after a pulse cut short by disable
module strobe_decoder
  import strobe_decoder_pkg::*;
#(
  parameter int SEL_W        = 3,
  parameter int PULSE_CYCLES = 1,
  parameter int DEAD_CYCLES  = 1,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_g1,
  input  logic [1:0]            en_g2,
  input  logic                  req,
  input  logic [SEL_W-1:0]      sel,
  output logic                  ready,
  output logic [2**SEL_W-1:0]   strobe,
  output logic                  done,
  output logic                  aborted
);

  localparam int             N      = 2 ** SEL_W;
  localparam logic           ACT_LO = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] P_LOAD = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] D_LOAD = CNT_W'(DEAD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (PULSE_CYCLES < 1 || PULSE_CYCLES > 255) begin : g_bad_pulse
    $error("strobe_decoder: PULSE_CYCLES must be in 1..255");
  end
  if (DEAD_CYCLES < 1 || DEAD_CYCLES > 255) begin : g_bad_dead
    $error("strobe_decoder: DEAD_CYCLES must be in 1..255");
  end
  if (SEL_W < 1) begin : g_bad_sel
    $error("strobe_decoder: SEL_W must be at least 1");
  end

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SEL_W-1:0] sel_q;
  logic [N-1:0]     strobe_q;
  logic             ready_q;
  logic             done_q;
  logic             aborted_q;

  logic             enabled;
  logic             accept;
  logic [SEL_W-1:0] dec_sel;
  logic [N-1:0]     onehot;
  logic [N-1:0]     strobe_on;
  logic [N-1:0]     strobe_off;

  assign enabled = en_g1 && (en_g2 == 2'b00);
  assign accept  = (state_q == IDLE) && req && enabled;

  // While idle the live sel is decoded so the line can go active on the
  // accepting edge; afterwards only the latched index is used.
  assign dec_sel = (state_q == IDLE) ? sel : sel_q;

  onehot_decode #(
    .SEL_W (SEL_W),
    .N     (N)
  ) u_decode (
    .sel_i    (dec_sel),
    .onehot_o (onehot)
  );

  always_comb begin
    strobe_on = '0;
    for (int i = 0; i < N; i++) begin
      strobe_on[i] = line_level(ACT_LO, onehot[i]);
    end
  end

  assign strobe_off = {N{ACT_LO}};

  always_ff @(posedge clk) begin
    if (accept) begin
      sel_q <= sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      strobe_q  <= strobe_off;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q  <= PULSE;
            cnt_q    <= P_LOAD;
            strobe_q <= strobe_on;
            ready_q  <= 1'b0;
          end
        end
        PULSE: begin
          // Disable wins over a normal end on the same cycle.
          if (!enabled) begin
            state_q   <= GAP;
            cnt_q     <= D_LOAD;
            strobe_q  <= strobe_off;
            aborted_q <= 1'b1;
          end else if (cnt_q == CNT_ONE) begin
            state_q  <= GAP;
            cnt_q    <= D_LOAD;
            strobe_q <= strobe_off;
            done_q   <= 1'b1;
          end else begin
            cnt_q    <= cnt_q - CNT_ONE;
            strobe_q <= strobe_on;
          end
        end
        GAP: begin
          if (cnt_q == CNT_ONE) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          strobe_q <= strobe_off;
          ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign ready   = ready_q;
  assign strobe  = strobe_q;
  assign done    = done_q;
  assign aborted = aborted_q;

endmodule

// File: tb/tb_strobe_decoder.sv
// tb_strobe_decoder
//   Four decoder instances with different parameter sets share stimulus;
//   dut_sel picks which one is observed. Expected outputs are queued when
//   stimulus is driven and popped after each clock edge.
module tb_strobe_decoder;

  logic        clk;
  logic        rst;
  logic        en_g1;
  logic [1:0]  en_g2;
  logic        req;
  logic [3:0]  sel4;

  logic [7:0]  stb0, stb1, stb2;
  logic [15:0] stb3;
  logic        rdy0, rdy1, rdy2, rdy3;
  logic        dn0, dn1, dn2, dn3;
  logic        ab0, ab1, ab2, ab3;

  int          dut_sel;
  logic [15:0] obs_stb;
  logic        obs_rdy, obs_dn, obs_ab;

  int n_checks;
  int n_errors;

  typedef struct {
    string       tag;
    logic [15:0] stb;
    logic        rdy;
    logic        dn;
    logic        ab;
  } exp_t;

  exp_t sb[$];

  strobe_decoder u0 (
    .clk(clk), .rst(rst), .en_g1(en_g1), .en_g2(en_g2), .req(req),
    .sel(sel4[2:0]), .ready(rdy0), .strobe(stb0), .done(dn0), .aborted(ab0)
  );

  strobe_decoder #(.PULSE_CYCLES(3), .DEAD_CYCLES(2)) u1 (
    .clk(clk), .rst(rst), .en_g1(en_g1), .en_g2(en_g2), .req(req),
    .sel(sel4[2:0]), .ready(rdy1), .strobe(stb1), .done(dn1), .aborted(ab1)
  );

  strobe_decoder #(.PULSE_CYCLES(4)) u2 (
    .clk(clk), .rst(rst), .en_g1(en_g1), .en_g2(en_g2), .req(req),
    .sel(sel4[2:0]), .ready(rdy2), .strobe(stb2), .done(dn2), .aborted(ab2)
  );

  strobe_decoder #(.SEL_W(4), .ACTIVE_LOW(0)) u3 (
    .clk(clk), .rst(rst), .en_g1(en_g1), .en_g2(en_g2), .req(req),
    .sel(sel4), .ready(rdy3), .strobe(stb3), .done(dn3), .aborted(ab3)
  );

  always_comb begin
    obs_stb = 16'h0000;
    obs_rdy = 1'b0;
    obs_dn  = 1'b0;
    obs_ab  = 1'b0;
    case (dut_sel)
      0: begin obs_stb = {8'h00, stb0}; obs_rdy = rdy0; obs_dn = dn0; obs_ab = ab0; end
      1: begin obs_stb = {8'h00, stb1}; obs_rdy = rdy1; obs_dn = dn1; obs_ab = ab1; end
      2: begin obs_stb = {8'h00, stb2}; obs_rdy = rdy2; obs_dn = dn2; obs_ab = ab2; end
      default: begin obs_stb = stb3; obs_rdy = rdy3; obs_dn = dn3; obs_ab = ab3; end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [15:0] s,
                      input logic r, input logic d, input logic a);
    exp_t e;
    e.tag = tag;
    e.stb = s;
    e.rdy = r;
    e.dn  = d;
    e.ab  = a;
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input string field,
                     input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
    end
  endtask

  // Advance one clock edge and compare the observed DUT against the oldest
  // queued expectation.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL scoreboard_empty observed=none expected=entry");
    end else begin
      e = sb.pop_front();
      chk(e.tag, "strobe",  obs_stb,        e.stb);
      chk(e.tag, "ready",   {15'd0, obs_rdy}, {15'd0, e.rdy});
      chk(e.tag, "done",    {15'd0, obs_dn},  {15'd0, e.dn});
      chk(e.tag, "aborted", {15'd0, obs_ab},  {15'd0, e.ab});
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    req = 1'b0;
    push(tag, (dut_sel == 3) ? 16'h0000 : 16'h00FF, 1'b1, 1'b0, 1'b0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    en_g1    = 1'b0;
    en_g2    = 2'b00;
    req      = 1'b0;
    sel4     = 4'd0;
    dut_sel  = 0;

    // Reset state of an active-low and an active-high instance
    push("reset_u0", 16'h00FF, 1'b1, 1'b0, 1'b0);
    step();
    dut_sel = 3;
    push("reset_u3", 16'h0000, 1'b1, 1'b0, 1'b0);
    step();

    // Defaults, sel=0 lights the MSB low for one cycle, then done
    dut_sel = 0;
    rst = 1'b0; en_g1 = 1'b1; en_g2 = 2'b00; req = 1'b1; sel4 = 4'd0;
    push("A_pulse", 16'h007F, 1'b0, 1'b0, 1'b0); step();
    req = 1'b0;
    push("A_gap",   16'h00FF, 1'b0, 1'b1, 1'b0); step();
    push("A_ready", 16'h00FF, 1'b1, 1'b0, 1'b0); step();

    // 3-cycle pulse, 2-cycle gap, sel changes after accept ignored,
    // disable during GAP/IDLE does not disturb timing
    dut_sel = 1;
    do_reset("B_reset");
    req = 1'b1; sel4 = 4'd5;
    push("B_p1", 16'h00FB, 1'b0, 1'b0, 1'b0); step();
    req = 1'b0; sel4 = 4'd7;
    push("B_p2", 16'h00FB, 1'b0, 1'b0, 1'b0); step();
    push("B_p3", 16'h00FB, 1'b0, 1'b0, 1'b0); step();
    push("B_g1", 16'h00FF, 1'b0, 1'b1, 1'b0); step();
    en_g1 = 1'b0;
    push("B_g2", 16'h00FF, 1'b0, 1'b0, 1'b0); step();
    push("B_idle", 16'h00FF, 1'b1, 1'b0, 1'b0); step();
    push("B_idle2", 16'h00FF, 1'b1, 1'b0, 1'b0); step();
    en_g1 = 1'b1;

    // Disable via en_g2 in the 2nd cycle of a 4-cycle pulse
    dut_sel = 2;
    do_reset("C_reset");
    req = 1'b1; sel4 = 4'd2;
    push("C_p1", 16'h00DF, 1'b0, 1'b0, 1'b0); step();
    req = 1'b0;
    push("C_p2", 16'h00DF, 1'b0, 1'b0, 1'b0); step();
    en_g2 = 2'b01;
    push("C_abort", 16'h00FF, 1'b0, 1'b0, 1'b1); step();
    en_g2 = 2'b00;
    push("C_gap_end", 16'h00FF, 1'b1, 1'b0, 1'b0); step();
    push("C_idle", 16'h00FF, 1'b1, 1'b0, 1'b0); step();

    // Active-high, 16 lines, req held: an accept every 3 cycles
    dut_sel = 3;
    do_reset("D_reset");
    req = 1'b1; sel4 = 4'd15;
    for (int k = 0; k < 3; k++) begin
      push("D_on",   16'h0001, 1'b0, 1'b0, 1'b0); step();
      push("D_gap",  16'h0000, 1'b0, 1'b1, 1'b0); step();
      push("D_idle", 16'h0000, 1'b1, 1'b0, 1'b0); step();
    end
    req = 1'b0;

    // Reset during the pulse kills the strobe without done/aborted
    dut_sel = 0;
    do_reset("E_reset");
    req = 1'b1; sel4 = 4'd2;
    push("E_pulse", 16'h00DF, 1'b0, 1'b0, 1'b0); step();
    req = 1'b0; rst = 1'b1;
    push("E_rst", 16'h00FF, 1'b1, 1'b0, 1'b0); step();
    rst = 1'b0;
    push("E_after",  16'h00FF, 1'b1, 1'b0, 1'b0); step();
    push("E_after2", 16'h00FF, 1'b1, 1'b0, 1'b0); step();

    // req while disabled is ignored; accept on first enabled cycle
    en_g1 = 1'b0; req = 1'b1; sel4 = 4'd1;
    for (int k = 0; k < 5; k++) begin
      push("F_disabled", 16'h00FF, 1'b1, 1'b0, 1'b0); step();
    end
    en_g1 = 1'b1;
    push("F_accept", 16'h00BF, 1'b0, 1'b0, 1'b0); step();
    req = 1'b0;
    push("F_gap",   16'h00FF, 1'b0, 1'b1, 1'b0); step();
    push("F_ready", 16'h00FF, 1'b1, 1'b0, 1'b0); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/strobe_decoder.md
STROBE_DECODER -- requirements
Module: strobe_decoder

Interface
REQ-001 Parameter SEL_W, default 3: select width; the block drives 2**SEL_W strobe lines (N below).
REQ-002 Parameter PULSE_CYCLES, default 1: cycles each strobe stays active; legal range 1..255.
REQ-003 Parameter DEAD_CYCLES, default 1: all-inactive cycles after each pulse; legal range 1..255.
REQ-004 Parameter ACTIVE_LOW, default 1: when 1 the active strobe level is 0; when 0 it is 1.
REQ-005 clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 en_g1  input  1  enable, active-high.
REQ-008 en_g2  input  2  enables, both active-low; the block is enabled only when en_g1=1 and en_g2=2'b00.
REQ-009 req  input  1  strobe request, qualified by ready.
REQ-010 sel  input  SEL_W  line index, sampled on accept.
REQ-011 ready  output  1  high only in IDLE.
REQ-012 strobe  output  N  registered one-hot (or one-cold) strobe lines.
REQ-013 done  output  1  one-cycle pulse when a pulse completes normally.
REQ-014 aborted  output  1  one-cycle pulse when a pulse is cut short by disable.

Function
REQ-015 The block SHALL implement the FSM states IDLE, PULSE and GAP.
REQ-016 Accept SHALL occur in a cycle where the state is IDLE, req=1 and the block is enabled; req while disabled SHALL be ignored with no later effect.
REQ-017 On accept at edge t, the FSM SHALL latch sel, enter PULSE, and drive strobe line index N-1-sel active from edge t onward; sel=0 maps to the MSB.
REQ-018 Exactly one strobe line SHALL be active in PULSE, and all lines SHALL be inactive in IDLE and GAP.
REQ-019 PULSE SHALL last exactly PULSE_CYCLES cycles, counted by a down-counter of width clog2(256).
REQ-020 From PULSE the FSM SHALL enter GAP, hold it for exactly DEAD_CYCLES cycles, then return to IDLE.
REQ-021 done SHALL pulse high in the first GAP cycle after a full-length pulse.
REQ-022 If the block becomes disabled during PULSE, the next edge SHALL make all strobes inactive, enter GAP with the counter reloaded to DEAD_CYCLES, and pulse aborted instead of done.
REQ-023 A disable during GAP or IDLE SHALL have no effect on timing.
REQ-024 req and sel changes outside the accept cycle SHALL be ignored; the latched sel SHALL be used for the whole pulse.
REQ-025 The minimum request-to-request spacing SHALL be 1+PULSE_CYCLES+DEAD_CYCLES cycles, and ready SHALL be 0 throughout PULSE and GAP.
REQ-026 Out-of-range PULSE_CYCLES or DEAD_CYCLES SHALL be rejected at elaboration.

Reset
REQ-027 While rst=1 at an edge: state=IDLE, counter=0, strobe=all inactive (all ones if ACTIVE_LOW=1, else all zeros), done=0, aborted=0.
REQ-028 ready SHALL read 1 from the first edge after rst deasserts; rst during PULSE SHALL kill the strobe at that same edge without asserting done or aborted.

Structure
REQ-029 The package strobe_decoder_pkg SHALL hold the FSM state enum, the counter width constant (8) and the level-select helper.
REQ-030 The sub-module onehot_decode (SEL_W in, N one-hot out, purely combinational) SHALL feed the strobe register; the FSM and counter SHALL stay in strobe_decoder.

Verification
REQ-031 Defaults, req=1, sel=3'b000 enabled -> strobe=8'b01111111 for 1 cycle, then 8'hFF for 1 cycle with done=1, then ready=1.
REQ-032 PULSE_CYCLES=3, DEAD_CYCLES=2, sel=3'b101 -> strobe=8'b11111011 for 3 cycles, all-ones for 2 cycles, accept-to-ready = 6 cycles.
REQ-033 PULSE_CYCLES=4, en_g2=2'b01 in the 2nd PULSE cycle -> strobe all-ones at the next edge, aborted=1 once, done never asserted.
REQ-034 ACTIVE_LOW=0, SEL_W=4, sel=4'd15 -> strobe=16'h0001 for one pulse; req held high continuously -> one accept every 3 cycles.
REQ-035 rst pulsed during PULSE with sel=3'b010 -> strobe=8'hFF at that edge, ready=1 after, done=0, aborted=0.
REQ-036 req=1 with en_g1=0 for 5 cycles, then en_g1=1 -> no strobe during the disabled cycles, and an accept on the first enabled cycle.
